rc_add_sub_seq: RTL and testbench
=================================

Name: rc_add_sub_seq

Overview:
- Multi-cycle sequencer that computes wide (32*NUM_WORDS-bit) add/subtract using one shared 32-bit ripple-carry add/sub slice.
- Processes one 32-bit word per cycle, LSW first, chaining carry through a register.
- Sits beside the ALU for wide-operand (e.g. 64-bit) arithmetic.
- Uses a START/BUSY/DONE handshake.

Parameters:
- NUM_WORDS, 2, number of 32-bit words per operand (legal range 1..8).
- W, 32*NUM_WORDS, derived total operand width (localparam, not overridable).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only when accepting (IDLE or DONE state).
- SnA  in  1  0 = add, 1 = subtract (A - B); latched at accept.
- A  in  W  operand A; latched at accept.
- B  in  W  operand B; latched at accept.
- Y  out  W  result register.
- CO  out  1  carry out of top word; for subtract, 1 = no borrow.
- OV  out  1  signed overflow flag (see Optional Feature).
- BUSY  out  1  high while words are being computed.
- DONE  out  1  one-cycle pulse; Y/CO/OV are valid from this cycle.

Behaviour:
- Reset (RST=1 at edge): state=IDLE, Y=0, CO=0, OV=0, BUSY=0, DONE=0, word index=0, carry reg=0, operand regs=0.
- States: IDLE, CALC, DONE.
- IDLE: if START=1, latch A, B, SnA; set carry reg=SnA and index=0; go to CALC. Otherwise stay.
- CALC (BUSY=1): each edge does the following:
  - Slice computes A_r[idx] + (B_r[idx] xor {32{SnA_r}}) + carry reg.
  - Sum is written to Y[32*idx+31:32*idx].
  - Carry reg takes the slice carry out.
  - idx increments.
  - When idx=NUM_WORDS-1 is written, go to DONE and load CO with the final carry.
- DONE (DONE=1, BUSY=0): lasts one cycle. If START=1, accept a new operation exactly as IDLE does (back-to-back); else go to IDLE.
- Latency:
  - START accepted at edge 0.
  - BUSY high for cycles 1..NUM_WORDS.
  - DONE high in cycle NUM_WORDS+1.
  - Throughput is one operation per NUM_WORDS+1 cycles.
- Y, CO and OV hold their values from DONE until the next accepted op begins writing.
- Words of Y not yet rewritten keep stale data while BUSY=1; Y is only guaranteed valid when DONE=1 or later in IDLE.
- START in CALC is ignored; there is no queueing.
- Operand changes after accept have no effect.
- RST asserted mid-CALC aborts: all state returns to reset values and no DONE pulse is produced.
- All arithmetic is modulo 2^W; there is no saturation.
- NUM_WORDS=1: CALC lasts a single cycle, and the result equals the plain 32-bit add/sub.

Optional Feature:
- Macro: RC_ADD_SUB_SEQ_OVERFLOW_EN.
- Defined:
  - A register captures the carry into bit 31 of the final word.
  - OV = carry_into_MSB xor final carry out, loaded with CO on the CALC→DONE edge.
  - OV is reset to 0.
- Undefined: OV is tied to 0 and no extra logic is generated. The port always exists.

Decomposition:
- Shared package / prj_definition.v constants: slice width 32 (DATA_INDEX_LIMIT+1); state encodings SEQ_IDLE=2'b00, SEQ_CALC=2'b01, SEQ_DONE=2'b10.
- Sub-module add_sub_slice_32: combinational 32-bit ripple-carry adder with explicit CI, pre-inverted B input, and outputs S[31:0], CO and C31 (carry into MSB).
  - The explicit CI is required for word chaining.
  - Exactly one instance is created.
- The sequencer contains the FSM, word index counter, operand/carry registers and result write mux.

Test Plan:
- NUM_WORDS=2, SnA=0, A=0x00000000_FFFFFFFF, B=0x1 → DONE in cycle 3 after accept; Y=0x00000001_00000000, CO=0, OV=0; BUSY high in cycles 1-2 only.
- SnA=1, A=0, B=1 → Y=0xFFFFFFFF_FFFFFFFF, CO=0 (borrow), OV=0. Then A=5, B=3 → Y=2, CO=1.
- OVERFLOW_EN defined: A=0x7FFFFFFF_FFFFFFFF + B=1 → Y=0x80000000_00000000, OV=1, CO=0. Undefined: same Y, OV=0.
- START pulsed in cycle 1 (CALC) with different operands → ignored; first result unchanged; exactly one DONE pulse.
- START held high through the DONE cycle with a new op → second op accepted at the DONE edge; second DONE appears 3 cycles later; no IDLE cycle in between.
- RST asserted in cycle 1 of CALC → next cycle Y=0, BUSY=0, DONE=0, state IDLE; no DONE pulse follows; a subsequent op completes correctly.

Source files
------------

// File: rtl/rc_add_sub_seq_pkg.sv
// Shared constants and types for the wide add/subtract sequencer.
//   DATA_INDEX_LIMIT : MSB index of one arithmetic slice word
//   SLICE_W          : width of the shared ripple-carry slice (32)
//   seq_state_e      : sequencer FSM encoding, also exported on the debug port
package rc_add_sub_seq_pkg;

  localparam int DATA_INDEX_LIMIT = 31;
  localparam int SLICE_W          = DATA_INDEX_LIMIT + 1;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_CALC = 2'b01,
    SEQ_DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/rc_add_sub_seq_add_sub_slice_32.sv
// add_sub_slice_32: combinational 32-bit ripple-carry adder used as the one
// shared arithmetic slice of the wide add/subtract sequencer.
// Subtraction is done by the caller pre-inverting B and driving ci_i = 1.
// Ports:
//   a_i   [31:0] in   operand word A
//   b_i   [31:0] in   operand word B, already inverted for subtract
//   ci_i         in   carry in (chained from the previous word)
//   s_o   [31:0] out  sum word
//   co_o         out  carry out of bit 31
//   c31_o        out  carry into bit 31 (used for signed overflow)
module add_sub_slice_32
  import rc_add_sub_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               ci_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               co_o,
  output logic               c31_o
);

  // c[i] is the carry into bit i; c[SLICE_W] is the carry out of the word.
  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = ci_i;
    for (int i = 0; i < SLICE_W; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign co_o  = c[SLICE_W];
  assign c31_o = c[SLICE_W-1];

endmodule

// File: rtl/rc_add_sub_seq.sv
// rc_add_sub_seq: multi-cycle wide (32*NUM_WORDS-bit) add/subtract built on a
// single shared 32-bit ripple-carry slice. One word per cycle, LSW first, with
// the carry chained through a register. START/BUSY/DONE handshake.
//
// Handshake: START is sampled only in IDLE or DONE; when sampled high, A, B and
// SnA are latched on that edge. BUSY is high for NUM_WORDS cycles after the
// accept, then DONE is high for exactly one cycle, from which Y/CO/OV are
// valid. START during BUSY is ignored; START during DONE starts the next
// operation with no idle gap.
//
// Optional feature macro: RC_ADD_SUB_SEQ_OVERFLOW_EN
//   defined   : OV = carry into bit 31 xor carry out of the final word
//   undefined : OV tied to 0, no overflow register
//
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   synchronous active-high reset
//   START        in   operation request
//   SnA          in   0 = A + B, 1 = A - B
//   A, B  [W-1:0] in  operands
//   Y     [W-1:0] out result register
//   CO           out  carry out of top word (subtract: 1 = no borrow)
//   OV           out  signed overflow flag
//   BUSY         out  words being computed
//   DONE         out  one-cycle completion pulse
//   dbg_state_o  out  current FSM state (seq_state_e encoding)
module rc_add_sub_seq
  import rc_add_sub_seq_pkg::*;
#(
  parameter  int NUM_WORDS = 2,
  localparam int W         = SLICE_W * NUM_WORDS
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         SnA,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Y,
  output logic         CO,
  output logic         OV,
  output logic         BUSY,
  output logic         DONE,
  output logic [1:0]   dbg_state_o
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  seq_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic sna_q, sna_d;
  logic co_q, co_d;
  logic [NUM_WORDS-1:0][SLICE_W-1:0] a_q, a_d;
  logic [NUM_WORDS-1:0][SLICE_W-1:0] b_q, b_d;
  logic [NUM_WORDS-1:0][SLICE_W-1:0] y_q, y_d;
`ifdef RC_ADD_SUB_SEQ_OVERFLOW_EN
  logic ov_q, ov_d;
`endif

  logic [SLICE_W-1:0] slice_s;
  logic slice_co;
  logic slice_c31;
  logic last_word;

  assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));

  // The slice always looks at the currently indexed word; its result is only
  // consumed while in CALC.
  add_sub_slice_32 u_slice (
    .a_i   (a_q[idx_q]),
    .b_i   (b_q[idx_q] ^ {SLICE_W{sna_q}}),
    .ci_i  (carry_q),
    .s_o   (slice_s),
    .co_o  (slice_co),
    .c31_o (slice_c31)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sna_d   = sna_q;
    co_d    = co_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
`ifdef RC_ADD_SUB_SEQ_OVERFLOW_EN
    ov_d    = ov_q;
`endif
    unique case (state_q)
      SEQ_IDLE, SEQ_DONE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          sna_d   = SnA;
          // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
          carry_d = SnA;
          idx_d   = '0;
          state_d = SEQ_CALC;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_CALC: begin
        y_d[idx_q] = slice_s;
        carry_d    = slice_co;
        idx_d      = idx_q + 1'b1;
        if (last_word) begin
          idx_d   = '0;
          co_d    = slice_co;
          state_d = SEQ_DONE;
`ifdef RC_ADD_SUB_SEQ_OVERFLOW_EN
          ov_d    = slice_c31 ^ slice_co;
`endif
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sna_q   <= 1'b0;
      co_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
`ifdef RC_ADD_SUB_SEQ_OVERFLOW_EN
      ov_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sna_q   <= sna_d;
      co_q    <= co_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
`ifdef RC_ADD_SUB_SEQ_OVERFLOW_EN
      ov_q    <= ov_d;
`endif
    end
  end

`ifdef RC_ADD_SUB_SEQ_OVERFLOW_EN
  assign OV = ov_q;
`else
  // Carry into bit 31 only matters for overflow detection.
  logic unused_c31;
  assign unused_c31 = slice_c31;
  assign OV = 1'b0;
`endif

  assign Y           = y_q;
  assign CO          = co_q;
  assign BUSY        = (state_q == SEQ_CALC);
  assign DONE        = (state_q == SEQ_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rc_add_sub_seq.sv
// Self-checking bench for rc_add_sub_seq (NUM_WORDS = 2, 64-bit operands).
// Inputs are driven and outputs sampled on the falling edge of CLK.
// Expected results {CO, OV, Y} come from a behavioural model and are queued
// when an operation is issued, then popped when DONE is observed.
module tb_rc_add_sub_seq;

  localparam int NW = 2;
  localparam int W  = 32 * NW;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         SnA;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Y;
  logic         CO;
  logic         OV;
  logic         BUSY;
  logic         DONE;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries are {CO, OV, Y}.
  logic [W+1:0] exp_q[$];

`ifdef RC_ADD_SUB_SEQ_OVERFLOW_EN
  localparam logic OV_EN = 1'b1;
`else
  localparam logic OV_EN = 1'b0;
`endif

  rc_add_sub_seq #(.NUM_WORDS(NW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .SnA         (SnA),
    .A           (A),
    .B           (B),
    .Y           (Y),
    .CO          (CO),
    .OV          (OV),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sna);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = sna ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(sna);
    ov   = OV_EN && (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {full[W], ov, full[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_w();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- driver ----------------
  // Issues one operation, scrambles operands after accept, and waits (bounded)
  // for DONE. lat is the cycle number after accept in which DONE was seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sna,
                        output int lat, output logic [W-1:0] y, output logic co,
                        output logic ov);
    @(negedge CLK);
    START = 1'b1; A = a; B = b; SnA = sna;
    exp_q.push_back(model(a, b, sna));
    @(negedge CLK);
    START = 1'b0; A = rand_w(); B = rand_w(); SnA = ~sna;
    lat = 1;
    while (!DONE && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    y = Y; co = CO; ov = OV;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1; START = 1'b1; SnA = 1'b0; A = rand_w(); B = rand_w();
    repeat (3) @(negedge CLK);
    n_checks += 6;
    if (Y !== '0)           begin n_fail++; $display("FAIL reset_y: got %h expected 0", Y); end
    if (CO !== 1'b0)        begin n_fail++; $display("FAIL reset_co: got %b expected 0", CO); end
    if (OV !== 1'b0)        begin n_fail++; $display("FAIL reset_ov: got %b expected 0", OV); end
    if (BUSY !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    if (DONE !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", DONE); end
    if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", dbg_state); end
    RST = 1'b0; START = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", BUSY); end
  endtask

  task automatic test_add_carry_chain();
    logic [W+1:0] exp;
    @(negedge CLK);
    START = 1'b1; SnA = 1'b0; A = 64'h0000_0000_FFFF_FFFF; B = 64'h1;
    exp_q.push_back(model(A, B, SnA));
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) begin START = 1'b0; A = rand_w(); B = rand_w(); end
      n_checks += 2;
      if (BUSY !== (cyc <= 2))
        begin n_fail++; $display("FAIL add_busy_c%0d: got %b expected %b", cyc, BUSY, cyc <= 2); end
      if (DONE !== (cyc == 3))
        begin n_fail++; $display("FAIL add_done_c%0d: got %b expected %b", cyc, DONE, cyc == 3); end
      if (cyc == 3) begin
        exp = exp_q.pop_front();
        n_checks += 3;
        if ({CO, OV, Y} !== exp)
          begin n_fail++; $display("FAIL add_result: got %h expected %h", {CO, OV, Y}, exp); end
        if (Y !== 64'h0000_0001_0000_0000)
          begin n_fail++; $display("FAIL add_y_lit: got %h expected 0000000100000000", Y); end
        if (CO !== 1'b0 || OV !== 1'b0)
          begin n_fail++; $display("FAIL add_flags: got co=%b ov=%b expected 0 0", CO, OV); end
      end
    end
    n_checks++;
    if (Y !== 64'h0000_0001_0000_0000)
      begin n_fail++; $display("FAIL add_y_hold: got %h expected 0000000100000000", Y); end
  endtask

  task automatic test_subtract();
    int lat; logic [W-1:0] y; logic co, ov; logic [W+1:0] exp;
    run_op(64'h0, 64'h1, 1'b1, lat, y, co, ov);
    exp = exp_q.pop_front();
    n_checks += 3;
    if (lat !== 3) begin n_fail++; $display("FAIL sub0_latency: got %0d expected 3", lat); end
    if ({co, ov, y} !== exp) begin n_fail++; $display("FAIL sub0_result: got %h expected %h", {co, ov, y}, exp); end
    if (y !== '1 || co !== 1'b0 || ov !== 1'b0)
      begin n_fail++; $display("FAIL sub0_lit: got y=%h co=%b ov=%b expected all-ones 0 0", y, co, ov); end
    run_op(64'h5, 64'h3, 1'b1, lat, y, co, ov);
    exp = exp_q.pop_front();
    n_checks += 2;
    if ({co, ov, y} !== exp) begin n_fail++; $display("FAIL sub1_result: got %h expected %h", {co, ov, y}, exp); end
    if (y !== 64'h2 || co !== 1'b1)
      begin n_fail++; $display("FAIL sub1_lit: got y=%h co=%b expected 2 1", y, co); end
  endtask

  task automatic test_overflow();
    int lat; logic [W-1:0] y; logic co, ov; logic [W+1:0] exp;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat, y, co, ov);
    exp = exp_q.pop_front();
    n_checks += 3;
    if ({co, ov, y} !== exp) begin n_fail++; $display("FAIL ovf_result: got %h expected %h", {co, ov, y}, exp); end
    if (y !== 64'h8000_0000_0000_0000 || co !== 1'b0)
      begin n_fail++; $display("FAIL ovf_y_co: got y=%h co=%b expected 8000000000000000 0", y, co); end
    if (ov !== OV_EN) begin n_fail++; $display("FAIL ovf_flag: got %b expected %b", ov, OV_EN); end
  endtask

  task automatic test_start_ignored();
    int dones; logic [W-1:0] y_seen; logic [W+1:0] exp;
    dones = 0; y_seen = '0;
    @(negedge CLK);
    START = 1'b1; SnA = 1'b0; A = 64'h1234_5678_9ABC_DEF0; B = 64'h0FED_CBA9_8765_4321;
    exp_q.push_back(model(A, B, SnA));
    @(negedge CLK);  // cycle 1, CALC: a new request here must be dropped
    START = 1'b1; SnA = 1'b1; A = rand_w(); B = rand_w();
    @(negedge CLK);
    START = 1'b0;
    for (int cyc = 2; cyc <= 9; cyc++) begin
      if (DONE) begin dones++; y_seen = Y; end
      if (cyc < 9) @(negedge CLK);
    end
    exp = exp_q.pop_front();
    n_checks += 2;
    if (dones !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", dones); end
    if (y_seen !== exp[W-1:0]) begin n_fail++; $display("FAIL ign_result: got %h expected %h", y_seen, exp[W-1:0]); end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] exp;
    logic busy_e, done_e;
    @(negedge CLK);
    START = 1'b1; SnA = 1'b0; A = rand_w(); B = rand_w();
    exp_q.push_back(model(A, B, SnA));
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) START = 1'b0;
      if (cyc == 2) begin
        START = 1'b1; SnA = 1'b1; A = rand_w(); B = rand_w();
        exp_q.push_back(model(A, B, SnA));
      end
      if (cyc == 4) begin START = 1'b0; A = rand_w(); B = rand_w(); end
      busy_e = (cyc == 1 || cyc == 2 || cyc == 4 || cyc == 5);
      done_e = (cyc == 3 || cyc == 6);
      n_checks += 2;
      if (BUSY !== busy_e) begin n_fail++; $display("FAIL b2b_busy_c%0d: got %b expected %b", cyc, BUSY, busy_e); end
      if (DONE !== done_e) begin n_fail++; $display("FAIL b2b_done_c%0d: got %b expected %b", cyc, DONE, done_e); end
      if (done_e) begin
        exp = exp_q.pop_front();
        n_checks++;
        if ({CO, OV, Y} !== exp)
          begin n_fail++; $display("FAIL b2b_result_c%0d: got %h expected %h", cyc, {CO, OV, Y}, exp); end
      end
    end
  endtask

  task automatic test_rst_abort();
    int dones, lat; logic [W-1:0] y; logic co, ov; logic [W+1:0] exp;
    dones = 0;
    @(negedge CLK);
    START = 1'b1; SnA = 1'b1; A = 64'h0; B = 64'h1;  // not queued: will be aborted
    @(negedge CLK);
    START = 1'b0; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_checks += 5;
    if (Y !== '0)            begin n_fail++; $display("FAIL abort_y: got %h expected 0", Y); end
    if (CO !== 1'b0 || OV !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got co=%b ov=%b expected 0 0", CO, OV); end
    if (BUSY !== 1'b0)       begin n_fail++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
    if (DONE !== 1'b0)       begin n_fail++; $display("FAIL abort_done: got %b expected 0", DONE); end
    if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL abort_state: got %b expected 00", dbg_state); end
    repeat (6) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    run_op(rand_w(), rand_w(), 1'b0, lat, y, co, ov);
    exp = exp_q.pop_front();
    n_checks++;
    if ({co, ov, y} !== exp) begin n_fail++; $display("FAIL abort_recover: got %h expected %h", {co, ov, y}, exp); end
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] y; logic co, ov; logic [W+1:0] exp;
    logic [W-1:0] a, b; logic sna;
    for (int i = 0; i < 12; i++) begin
      a = rand_w(); b = rand_w(); sna = 1'($urandom_range(0, 1));
      if (i == 0) b = a;                      // equal operands
      if (i == 1) begin a = '1; b = '1; end   // all ones
      run_op(a, b, sna, lat, y, co, ov);
      exp = exp_q.pop_front();
      n_checks += 2;
      if (lat !== 3) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected 3", i, lat); end
      if ({co, ov, y} !== exp) begin n_fail++; $display("FAIL rand%0d_result: got %h expected %h", i, {co, ov, y}, exp); end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  // ---------------- sequence & report ----------------
  initial begin
    RST = 1'b1; START = 1'b0; SnA = 1'b0; A = '0; B = '0;
    test_reset();
    test_add_carry_chain();
    test_subtract();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_rst_abort();
    test_random();
    n_checks++;
    if (exp_q.size() !== 0)
      begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
